rv_mul_unit: RTL and testbench
==============================

RV_MUL_UNIT -- requirements
Module: rv_mul_unit

Interface
REQ-001 SHALL have parameter RADIX_BITS, default 1, meaning multiplier bits retired per cycle; legal values 1, 2, 4.
REQ-002 SHALL have derived local constant N_ITER = 32/RADIX_BITS, meaning the number of iteration cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: execute-stage issue request for an M-extension multiply.
REQ-006 SHALL have port func3, input, 3 bits: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-007 SHALL have port op_a, input, 32 bits: rs1 operand value (word_t).
REQ-008 SHALL have port op_b, input, 32 bits: rs2 operand value (word_t).
REQ-009 SHALL have port flush, input, 1 bit: execute-stage flush from the hazard logic.
REQ-010 SHALL have port mul_busy, output, 1 bit: stall request to the pipeline.
REQ-011 SHALL have port done, output, 1 bit: result-valid strobe.
REQ-012 SHALL have port mul_res, output, 32 bits: registered product word.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 SHALL accept a request in IDLE or DONE when start=1, func3[2]=0 and flush=0; accept SHALL latch operands, sign flags and func3, load iteration counter with N_ITER and go to CALC.
REQ-015 SHALL ignore start while in CALC, when func3[2]=1, or when flush=1 in the same cycle.
REQ-016 SHALL drive mul_busy combinationally as (accept condition in this cycle) OR (state==CALC), so a request stalls the pipeline from its issue cycle.
REQ-017 SHALL retire RADIX_BITS multiplier bits per CALC cycle into a 64-bit unsigned shift-add accumulator, decrementing the counter each cycle.
REQ-018 SHALL go from CALC to DONE when the counter reaches 1; an accept at cycle T gives CALC in T+1..T+N_ITER, DONE at T+N_ITER+1, mul_busy low at T+N_ITER+1.
REQ-019 SHALL convert operands to magnitudes by sign: op_a signed for MULH and MULHSU; op_b signed for MULH only. The 32-bit magnitude of 0x80000000 SHALL be 2^31 (no overflow).
REQ-020 SHALL negate the 64-bit magnitude product (two's complement) when the operand signs differ, on entry to DONE.
REQ-021 SHALL load mul_res on entry to DONE with bits [31:0] for MUL, else bits [63:32].
REQ-022 SHALL hold mul_res until the next entry to DONE.
REQ-023 SHALL drive done = (state==DONE) AND NOT flush; DONE SHALL last one cycle, then go to IDLE unless a new accept occurs.
REQ-024 SHALL, on flush=1 in CALC, abort to IDLE next cycle: no done, mul_res unchanged, mul_busy low from the following cycle.
REQ-025 SHALL NOT produce an early-out; latency is fixed regardless of operand values.

Reset
REQ-026 SHALL, while rst=1 at any time including mid-CALC, force state IDLE, mul_busy=0, done=0, mul_res=0x00000000, counter=0, accumulator=0.
REQ-027 SHALL allow the first accept in the first rising clk edge after rst deasserts.

Verification
REQ-028 SHALL check MUL, RADIX_BITS=1: op_a=7, op_b=0xFFFFFFFD, start at T -> mul_busy high T..T+32; done=1 and mul_res=0xFFFFFFEB at T+33.
REQ-029 SHALL check MULH: 0x80000000 x 0x80000000 -> mul_res=0x40000000. Also MULH 0xFFFFFFFF x 0x00000001 -> 0xFFFFFFFF.
REQ-030 SHALL check MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF, and MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 SHALL check flush at T+10 of a CALC -> IDLE at T+11, no done, mul_res keeps prior value; a start with flush=1 in the same cycle is not accepted.
REQ-032 SHALL check rst pulse mid-CALC -> outputs zero asynchronously; a new MULHU 3 x 5 (then MUL 3 x 5 = 0x0000000F) completes with correct latency.
REQ-033 SHALL check back-to-back: start held high through DONE -> second request accepted in the DONE cycle. Also RADIX_BITS=4 latency: done at T+9.

Source files
------------

// File: rtl/rv_mul_unit.sv
// Iterative RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU).
// Shift-add on operand magnitudes, RADIX_BITS multiplier bits per cycle, fixed latency.
module rv_mul_unit #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        mul_busy,
  output logic        done,
  output logic [31:0] mul_res
);

  localparam int N_ITER = 32 / RADIX_BITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic        r_neg;
  logic        r_is_mul;
  logic [31:0] r_res;

  logic        w_accept;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_acc_next;
  logic [63:0] w_prod;
  logic        w_last;

  assign w_accept   = start & ~func3[2] & ~flush & (r_state != CALC);
  assign w_a_signed = (func3[1:0] == 2'b01) | (func3[1:0] == 2'b10);
  assign w_b_signed = (func3[1:0] == 2'b01);
  assign w_a_neg    = w_a_signed & op_a[31];
  assign w_b_neg    = w_b_signed & op_b[31];
  // Negating 0x80000000 yields 0x80000000, which read unsigned is exactly 2^31.
  assign w_a_mag    = w_a_neg ? (~op_a + 32'd1) : op_a;
  assign w_b_mag    = w_b_neg ? (~op_b + 32'd1) : op_b;
  assign w_last     = (r_cnt == 6'd1);

  always_comb begin
    w_acc_next = r_acc;
    for (int j = 0; j < RADIX_BITS; j++) begin
      if (r_mplier[j]) begin
        w_acc_next = w_acc_next + (r_mcand << j);
      end
    end
  end

  assign w_prod   = r_neg ? (~w_acc_next + 64'd1) : w_acc_next;

  assign mul_busy = w_accept | (r_state == CALC);
  assign done     = (r_state == DONE) & ~flush;
  assign mul_res  = r_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 6'd0;
      r_acc    <= 64'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_neg    <= 1'b0;
      r_is_mul <= 1'b0;
      r_res    <= 32'd0;
    end else begin
      case (r_state)
        CALC: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << RADIX_BITS;
            r_mplier <= r_mplier >> RADIX_BITS;
            r_cnt    <= r_cnt - 6'd1;
            if (w_last) begin
              r_state <= DONE;
              r_res   <= r_is_mul ? w_prod[31:0] : w_prod[63:32];
            end
          end
        end
        default: begin
          if (w_accept) begin
            r_state  <= CALC;
            r_cnt    <= 6'(N_ITER);
            r_acc    <= 64'd0;
            r_mcand  <= {32'd0, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_is_mul <= (func3[1:0] == 2'b00);
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mul_unit.sv
// Self-checking bench: RADIX_BITS=1 and RADIX_BITS=4 instances share stimulus and are
// compared every cycle against a cycle-count/arithmetic reference model.
module tb_rv_mul_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [31:0] res [2];

  int n_chk  = 0;
  int n_fail = 0;

  // Model state per instance: remaining CALC cycles, in-DONE flag, result register.
  int          m_cnt   [2];
  logic        m_dflag [2];
  logic [31:0] m_res   [2];
  logic [31:0] m_pend  [2];

  rv_mul_unit #(.RADIX_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .mul_busy(busy[0]), .done(done[0]), .mul_res(res[0])
  );

  rv_mul_unit #(.RADIX_BITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .mul_busy(busy[1]), .done(done[1]), .mul_res(res[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f[1:0] == 2'b01 || f[1:0] == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (f[1:0] == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int n_iter(int k);
    return (k == 0) ? 32 : 8;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_model;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_dflag[k] = 1'b0; m_res[k] = 32'd0; m_pend[k] = 32'd0;
    end
  endtask

  // Per-cycle compare at negedge, model advance at posedge.
  initial begin
    logic acc;
    zero_model();
    forever begin
      @(negedge clk);
      if (rst) zero_model();
      for (int k = 0; k < 2; k++) begin
        acc = start && !func3[2] && !flush && (m_cnt[k] == 0) && !rst;
        check($sformatf("busy[%0d]", k), {31'd0, busy[k]},
              {31'd0, acc || (m_cnt[k] != 0 && !rst)});
        check($sformatf("done[%0d]", k), {31'd0, done[k]},
              {31'd0, m_dflag[k] && !flush && !rst});
        check($sformatf("res[%0d]", k), res[k], m_res[k]);
      end
      @(posedge clk);
      if (rst) begin
        zero_model();
      end else begin
        for (int k = 0; k < 2; k++) begin
          acc = start && !func3[2] && !flush && (m_cnt[k] == 0);
          if (acc) begin
            m_cnt[k]   = n_iter(k);
            m_pend[k]  = ref_mul(func3, op_a, op_b);
            m_dflag[k] = 1'b0;
          end else if (m_cnt[k] != 0) begin
            if (flush) begin
              m_cnt[k] = 0;
            end else begin
              if (m_cnt[k] == 1) begin
                m_dflag[k] = 1'b1;
                m_res[k]   = m_pend[k];
              end
              m_cnt[k]--;
            end
          end else begin
            m_dflag[k] = 1'b0;
          end
        end
      end
    end
  end

  // Wait (bounded) for done on the radix-1 instance; returns the cycle offsets of done.
  task automatic wait_done(output int d1, output int d4);
    d1 = 0; d4 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done[1] && d4 == 0) d4 = c;
      if (done[0]) begin
        d1 = c;
        break;
      end
      tick();
    end
    if (d1 == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Issue one request from the current cycle T; check latency and final result.
  task automatic issue(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
    int d1, d4;
    start = 1'b1; func3 = f; op_a = a; op_b = b;
    tick();
    start = 1'b0;
    wait_done(d1, d4);
    check("lat_r1", d1, 33);
    check("lat_r4", d4, 9);
    check("res_r1", res[0], exp);
    check("res_r4", res[1], exp);
    tick();
  endtask

  initial begin
    int d1, d4, seen;
    logic [31:0] held;
    logic [31:0] specials [6];
    specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'h8000_0000;
    specials[3] = 32'h7FFF_FFFF; specials[4] = 32'h0000_0001; specials[5] = 32'h0000_0003;

    rst = 1'b1; start = 1'b0; func3 = 3'd0; op_a = 32'd0; op_b = 32'd0; flush = 1'b0;
    repeat (3) tick();
    check("rst_res", res[0], 32'd0);
    check("rst_busy", {31'd0, busy[0]}, 32'd0);
    rst = 1'b0;

    // Pin the model with hand-computed values.
    check("model_mul", ref_mul(3'b000, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("model_mulh", ref_mul(3'b001, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("model_mulhsu", ref_mul(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    check("model_mulhu", ref_mul(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

    // First accept right after reset release.
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    issue(3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Back-to-back: start held through DONE is accepted in the DONE cycle.
    start = 1'b1; func3 = 3'b000; op_a = 32'd1234; op_b = 32'd5678;
    tick();
    wait_done(d1, d4);
    check("b2b_lat1", d1, 33);
    check("b2b_busy_in_done", {31'd0, busy[0]}, 32'd1);
    tick();
    start = 1'b0;
    wait_done(d1, d4);
    check("b2b_lat2", d1, 33);
    check("b2b_res", res[0], 32'd7006652);
    tick();
    repeat (10) tick();

    // Flush at T+10 aborts; result register keeps its previous value.
    held = res[0];
    start = 1'b1; func3 = 3'b000; op_a = 32'd99; op_b = 32'd77;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy[0]}, 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done[0]) seen = 1;
      tick();
    end
    check("flush_no_done", seen, 0);
    check("flush_res_kept", res[0], held);
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("start_flush_busy", {31'd0, busy[0]}, 32'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start_flush_idle", {31'd0, busy[0]}, 32'd0);
    tick();

    // Randomised traffic, checked every cycle by the model.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(3) == 0);
      func3 = ($urandom_range(5) == 0) ? 3'(4 + $urandom_range(3)) : 3'($urandom_range(3));
      op_a  = ($urandom_range(2) == 0) ? specials[$urandom_range(5)] : $urandom;
      op_b  = ($urandom_range(2) == 0) ? specials[$urandom_range(5)] : $urandom;
      flush = ($urandom_range(11) == 0);
      tick();
    end
    start = 1'b0; flush = 1'b0;
    repeat (40) tick();

    // Reset mid-CALC clears outputs asynchronously.
    start = 1'b1; func3 = 3'b011; op_a = 32'd3; op_b = 32'd5;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy[0]}, 32'd0);
    check("arst_done", {31'd0, done[0]}, 32'd0);
    check("arst_res", res[0], 32'd0);
    tick();
    rst = 1'b0;
    issue(3'b011, 32'd3, 32'd5, 32'h0000_0000);
    issue(3'b000, 32'd3, 32'd5, 32'h0000_000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
